// File: rtl/mouse_canvas_tracker.sv
// Integrates PS/2 movement packets into a clamped screen cursor and turns
// left-button drags inside the handwriting window into 28x28 canvas writes.
module mouse_canvas_tracker #(
  parameter int SCR_W     = 640,
  parameter int SCR_H     = 480,
  parameter int CANVAS_X0 = 208,
  parameter int CANVAS_Y0 = 128,
  parameter int CELL_LOG2 = 3,
  parameter int GRID      = 28
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [8:0] xm,
  input  logic [8:0] ym,
  input  logic [2:0] button,
  output logic [9:0] cur_x,
  output logic [9:0] cur_y,
  output logic       btn_l,
  output logic       wr_en,
  output logic [9:0] wr_addr,
  output logic       wr_data,
  output logic       clear_busy
);

  typedef enum logic [1:0] {IDLE, CALC, PAINT, CLEAR} state_t;

  localparam int CANVAS_PX = GRID << CELL_LOG2;
  localparam int CELL_W    = $clog2(GRID);
  localparam logic signed [11:0] X_MAX = 12'(SCR_W - 1);
  localparam logic signed [11:0] Y_MAX = 12'(SCR_H - 1);
  localparam logic [9:0] LAST_ADDR = 10'(GRID * GRID - 1);

  state_t state, state_nxt;
  logic [8:0] xm_q, ym_q, xm_nxt, ym_nxt;
  logic [2:0] btn_q, btn_nxt;
  logic [9:0] cur_x_nxt, cur_y_nxt, wr_addr_nxt;
  logic       btn_l_nxt, wr_en_nxt, wr_data_nxt, clear_busy_nxt;

  logic signed [11:0] nx_raw, ny_raw;
  logic [9:0]         cx, cy;
  logic               in_canvas;
  logic [CELL_W-1:0]  col, row;
  logic [9:0]         row10, paint_addr;
  logic               unused_mid;

  // The middle button is captured with the packet but drives nothing.
  assign unused_mid = btn_q[2];

  assign nx_raw = $signed({2'b00, cur_x}) + $signed({{3{xm_q[8]}}, xm_q});
  assign ny_raw = $signed({2'b00, cur_y}) - $signed({{3{ym_q[8]}}, ym_q});

  always_comb begin
    cx = nx_raw[9:0];
    cy = ny_raw[9:0];
    if (nx_raw < 0)          cx = '0;
    else if (nx_raw > X_MAX) cx = X_MAX[9:0];
    if (ny_raw < 0)          cy = '0;
    else if (ny_raw > Y_MAX) cy = Y_MAX[9:0];
  end

  assign in_canvas = (cx >= 10'(CANVAS_X0)) && (cx < 10'(CANVAS_X0 + CANVAS_PX)) &&
                     (cy >= 10'(CANVAS_Y0)) && (cy < 10'(CANVAS_Y0 + CANVAS_PX));

  // Multiply-free row*28 for the fixed 28-cell grid.
  assign col        = CELL_W'((cx - 10'(CANVAS_X0)) >> CELL_LOG2);
  assign row        = CELL_W'((cy - 10'(CANVAS_Y0)) >> CELL_LOG2);
  assign row10      = 10'(row);
  assign paint_addr = (row10 << 4) + (row10 << 3) + (row10 << 2) + 10'(col);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      xm_q       <= '0;
      ym_q       <= '0;
      btn_q      <= '0;
      cur_x      <= 10'(SCR_W / 2);
      cur_y      <= 10'(SCR_H / 2);
      btn_l      <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 1'b0;
      clear_busy <= 1'b0;
    end else begin
      state      <= state_nxt;
      xm_q       <= xm_nxt;
      ym_q       <= ym_nxt;
      btn_q      <= btn_nxt;
      cur_x      <= cur_x_nxt;
      cur_y      <= cur_y_nxt;
      btn_l      <= btn_l_nxt;
      wr_en      <= wr_en_nxt;
      wr_addr    <= wr_addr_nxt;
      wr_data    <= wr_data_nxt;
      clear_busy <= clear_busy_nxt;
    end
  end

  // Write strobes are decided one state early so they land registered in
  // the PAINT/CLEAR cycles themselves.
  always_comb begin
    state_nxt      = state;
    xm_nxt         = xm_q;
    ym_nxt         = ym_q;
    btn_nxt        = btn_q;
    cur_x_nxt      = cur_x;
    cur_y_nxt      = cur_y;
    btn_l_nxt      = btn_l;
    wr_en_nxt      = 1'b0;
    wr_addr_nxt    = wr_addr;
    wr_data_nxt    = wr_data;
    clear_busy_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (pkt_valid) begin
          xm_nxt    = xm;
          ym_nxt    = ym;
          btn_nxt   = button;
          state_nxt = CALC;
        end
      end
      CALC: begin
        cur_x_nxt = cx;
        cur_y_nxt = cy;
        btn_l_nxt = btn_q[0];
        if (btn_q[1]) begin
          state_nxt      = CLEAR;
          wr_en_nxt      = 1'b1;
          wr_data_nxt    = 1'b0;
          wr_addr_nxt    = '0;
          clear_busy_nxt = 1'b1;
        end else if (btn_q[0] && in_canvas) begin
          state_nxt   = PAINT;
          wr_en_nxt   = 1'b1;
          wr_data_nxt = 1'b1;
          wr_addr_nxt = paint_addr;
        end else begin
          state_nxt = IDLE;
        end
      end
      PAINT: state_nxt = IDLE;
      CLEAR: begin
        if (wr_addr == LAST_ADDR) begin
          state_nxt   = IDLE;
          wr_addr_nxt = '0;
        end else begin
          wr_en_nxt      = 1'b1;
          clear_busy_nxt = 1'b1;
          wr_addr_nxt    = wr_addr + 10'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/mouse_canvas_tracker.md
Name: mouse_canvas_tracker

Overview:
- Sits directly downstream of the PS/2 mouse interface. Consumes each decoded movement packet: 9-bit two's-complement dx/dy, button bits, and a one-cycle packet-done strobe.
- Integrates the packet into an absolute, clamped screen cursor.
- Translates left-button drags inside the handwriting window into single-cell writes to a 28x28 canvas RAM. A right-button press sweeps a clear over the whole canvas.
- Feeds the VGA cursor overlay and the canvas RAM that the DNN input stage reads.

Parameters:
- SCR_W, 640, screen width in pixels; cursor x range 0..SCR_W-1.
- SCR_H, 480, screen height in pixels; cursor y range 0..SCR_H-1.
- CANVAS_X0, 208, screen x of canvas left edge.
- CANVAS_Y0, 128, screen y of canvas top edge.
- CELL_LOG2, 3, log2 of screen pixels per canvas cell (8x8 px per cell, canvas 224x224 px).
- GRID, 28, canvas cells per side; RAM depth GRID*GRID = 784.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- pkt_valid  in  1  one-cycle strobe: xm/ym/button hold a complete new packet.
- xm  in  9  signed x movement; positive = right.
- ym  in  9  signed y movement; positive = up (PS/2 convention).
- button  in  3  {middle, right, left}.
- cur_x  out  10  cursor screen x.
- cur_y  out  10  cursor screen y; 0 = top.
- btn_l  out  1  left-button state from last accepted packet.
- wr_en  out  1  canvas RAM write strobe.
- wr_addr  out  10  canvas address = row*GRID + col.
- wr_data  out  1  1 = ink, 0 = blank.
- clear_busy  out  1  high while clear sweep runs.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. All outputs are registered.
- Reset values: cur_x = SCR_W/2 (320), cur_y = SCR_H/2 (240), btn_l = 0, wr_en = 0, wr_addr = 0, wr_data = 0, clear_busy = 0, state = IDLE.
- States: IDLE, CALC, PAINT, CLEAR.
- IDLE:
  - pkt_valid=1 latches xm, ym, button; goes to CALC.
  - pkt_valid=0 stays in IDLE; wr_en = 0.
- CALC (1 cycle):
  - Compute nx = cur_x + sext(xm) and ny = cur_y - sext(ym), both as 12-bit signed.
  - Clamp: negative -> 0; nx > SCR_W-1 -> SCR_W-1; ny > SCR_H-1 -> SCR_H-1.
  - Register clamped values into cur_x/cur_y and button[0] into btn_l.
  - Next state:
    - button[1]=1 -> CLEAR; right has priority over left.
    - Else button[0]=1 and clamped point is inside the canvas -> PAINT. Inside means CANVAS_X0 <= nx < CANVAS_X0 + (GRID<<CELL_LOG2), and the same test for y.
    - Otherwise -> IDLE.
- PAINT (1 cycle):
  - wr_en=1, wr_data=1.
  - col = (cur_x - CANVAS_X0) >> CELL_LOG2; row = (cur_y - CANVAS_Y0) >> CELL_LOG2.
  - wr_addr = row*28 + col, computed as (row<<4) + (row<<3) + (row<<2) + col, range 0..783.
  - Next state IDLE.
- CLEAR:
  - clear_busy=1, wr_en=1, wr_data=0.
  - wr_addr starts at 0 and increments each cycle.
  - After the cycle with wr_addr = 783: clear_busy=0, wr_en=0, wr_addr=0, next state IDLE.
  - Exactly 784 writes, no skipped or repeated addresses.
- Latency: pkt_valid high in cycle N -> new cur_x/cur_y/btn_l visible in cycle N+2.
  - Paint write pulse also in cycle N+2, exactly one cycle wide.
  - Clear writes occupy cycles N+2..N+785; IDLE again in cycle N+786.
- wr_en is 0 in IDLE and CALC, always.
- pkt_valid while state != IDLE: the packet is ignored entirely. No position update, no write. Packet rate of about 100 Hz makes this harmless.
- Middle button is latched but unused.
- Cursor at a clamp boundary: further outward motion leaves it unchanged; inward motion applies normally.
- Edge pixel mapping:
  - Cursor exactly at CANVAS_X0/CANVAS_Y0 -> cell (0,0), addr 0.
  - Cursor at CANVAS_X0+223/CANVAS_Y0+223 -> addr 783.
  - Cursor at CANVAS_X0+224 or CANVAS_Y0+224 -> outside canvas, no write.
- Reset mid-CLEAR or mid-PAINT: next cycle all outputs at reset values. The sweep aborts and is not resumed.
- Reset asserted in the same cycle as pkt_valid: reset wins, packet dropped.

Test Plan:
1. Reset, then packet xm=+10, ym=+5, button=0 -> cur_x=330, cur_y=235 at N+2; wr_en never asserted.
2. From reset, 5 packets xm=-256 (9'h100), ym=-255 (9'h101) -> cur_x clamps to 0 after packet 2; cur_y clamps to 479 after packet 1 (240+255=495). Further packets leave (0,479).
3. Cursor driven to (208,128), then packet xm=0, ym=0, button=001 -> single wr_en pulse at N+2 with wr_addr=0, wr_data=1. Repeat at (431,351) -> wr_addr=783. At (432,351) -> no write.
4. Cursor at (216,136), button=001 -> wr_addr=29 (row 1, col 1).
5. Packet button=011 -> no ink write.
   - clear_busy high N+2..N+785, 784 writes of wr_data=0, addresses 0..783 in order.
   - A pkt_valid at N+100 is ignored; cursor unchanged.
6. Reset asserted during the clear at wr_addr=400 -> next cycle wr_en=0, clear_busy=0, cur=(320,240), state IDLE. A following packet is processed normally.
